// File: rtl/sprite_blitter.sv
// Sprite blitter: walks sprite-local coordinates, reads the texel ROM and emits
// framebuffer writes at screen coordinates with flip, upscale, clipping and transparency.
module sprite_blitter #(
  parameter int HWIDTH      = 10,
  parameter int VWIDTH      = 10,
  parameter int AWIDTH      = 12,
  parameter int FWIDTH      = 19,
  parameter int DWIDTH      = 12,
  parameter int IWIDTH      = 0,
  parameter int HSIZE       = 32,
  parameter int VSIZE       = 32,
  parameter int HRES        = 640,
  parameter int VRES        = 480,
  parameter int TRANSPARENT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [HWIDTH-1:0] hoffset,
  input  logic [VWIDTH-1:0] voffset,
  input  logic              hflip,
  input  logic              vflip,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_data,
  output logic              fb_we,
  input  logic              fb_ready,
  output logic [FWIDTH-1:0] fb_addr,
  output logic [DWIDTH-1:0] fb_data,
  output logic [2:0]        fsm_state
);

  localparam int XW  = (HSIZE > 1) ? $clog2(HSIZE) : 1;
  localparam int YW  = (VSIZE > 1) ? $clog2(VSIZE) : 1;
  localparam int SXW = HWIDTH + 1;
  localparam int SYW = VWIDTH + 1;

  // Write port handshake: fb_we is valid, a write completes on a rising edge
  // with fb_we && fb_ready; fb_we/fb_addr/fb_data stay frozen until then.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [XW-1:0]     x, x_nx;
  logic [YW-1:0]     y, y_nx;
  logic [HWIDTH-1:0] hoff, hoff_nx;
  logic [VWIDTH-1:0] voff, voff_nx;
  logic              hf, hf_nx, vf, vf_nx;
  logic [AWIDTH-1:0] rom_addr_nx;
  logic              fb_we_nx;
  logic [FWIDTH-1:0] fb_addr_nx;
  logic [DWIDTH-1:0] fb_data_nx;
  logic [SXW-1:0]    sx;
  logic [SYW-1:0]    sy;
  logic              visible, last, advance;

  function automatic logic [AWIDTH-1:0] src_addr(input logic [XW-1:0] xi, input logic [YW-1:0] yi,
                                                 input logic hfl, input logic vfl);
    logic [XW-1:0]     hx;
    logic [YW-1:0]     vy;
    logic [AWIDTH-1:0] row, col;
    hx  = hfl ? (XW'(HSIZE - 1) - xi) : xi;
    vy  = vfl ? (YW'(VSIZE - 1) - yi) : yi;
    row = AWIDTH'(vy >> IWIDTH);
    col = AWIDTH'(hx >> IWIDTH);
    return AWIDTH'(row * AWIDTH'(HSIZE >> IWIDTH)) + col;
  endfunction

  // Destination is one bit wider than the offset so off-screen pixels never wrap back on.
  assign sx        = SXW'(hoff) + SXW'(x);
  assign sy        = SYW'(voff) + SYW'(y);
  assign visible   = (sx < SXW'(HRES)) && (sy < SYW'(VRES));
  assign last      = (x == XW'(HSIZE - 1)) && (y == YW'(VSIZE - 1));
  assign busy      = (state == FETCH) || (state == WAIT) || (state == WRITE);
  assign done      = (state == DONE);
  assign fsm_state = state;

  always_comb begin
    state_nx    = state;
    x_nx        = x;
    y_nx        = y;
    hoff_nx     = hoff;
    voff_nx     = voff;
    hf_nx       = hf;
    vf_nx       = vf;
    rom_addr_nx = rom_addr;
    fb_we_nx    = fb_we;
    fb_addr_nx  = fb_addr;
    fb_data_nx  = fb_data;
    advance     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          hoff_nx     = hoffset;
          voff_nx     = voffset;
          hf_nx       = hflip;
          vf_nx       = vflip;
          x_nx        = '0;
          y_nx        = '0;
          rom_addr_nx = src_addr('0, '0, hflip, vflip);
          state_nx    = FETCH;
        end
      end
      FETCH: state_nx = WAIT;
      WAIT: begin
        if (visible && (rom_data != DWIDTH'(TRANSPARENT))) begin
          fb_we_nx   = 1'b1;
          fb_addr_nx = FWIDTH'(sy) * FWIDTH'(HRES) + FWIDTH'(sx);
          fb_data_nx = rom_data;
          state_nx   = WRITE;
        end else begin
          advance = 1'b1;
        end
      end
      WRITE: begin
        if (fb_ready) begin
          fb_we_nx = 1'b0;
          advance  = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // The next pixel's ROM address is registered on the way into FETCH.
    if (advance) begin
      if (last) begin
        state_nx = DONE;
      end else begin
        if (x == XW'(HSIZE - 1)) begin
          x_nx = '0;
          y_nx = y + YW'(1);
        end else begin
          x_nx = x + XW'(1);
        end
        rom_addr_nx = src_addr(x_nx, y_nx, hf, vf);
        state_nx    = FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      hoff     <= '0;
      voff     <= '0;
      hf       <= 1'b0;
      vf       <= 1'b0;
      rom_addr <= '0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
    end else begin
      state    <= state_nx;
      x        <= x_nx;
      y        <= y_nx;
      hoff     <= hoff_nx;
      voff     <= voff_nx;
      hf       <= hf_nx;
      vf       <= vf_nx;
      rom_addr <= rom_addr_nx;
      fb_we    <= fb_we_nx;
      fb_addr  <= fb_addr_nx;
      fb_data  <= fb_data_nx;
    end
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Sprite blitter that copies one sprite from its texel ROM into the framebuffer at a screen offset, with optional horizontal/vertical flip, power-of-two upscale, screen-edge clipping and transparent-colour skipping. It performs the reverse of the display-side lookup: it walks sprite-local coordinates, reads the texel ROM, and emits framebuffer write requests at screen coordinates. It sits between the game-logic sprite scheduler (start/done) and the framebuffer write port (valid/ready).

## Interface
- HWIDTH, 10, horizontal coordinate width
- VWIDTH, 10, vertical coordinate width
- AWIDTH, 12, texel ROM address width
- FWIDTH, 19, framebuffer address width
- DWIDTH, 12, pixel data width
- IWIDTH, 0, upscale shift; each texel covers 2^IWIDTH x 2^IWIDTH screen pixels
- HSIZE, 32, sprite width in screen pixels, multiple of 2^IWIDTH
- VSIZE, 32, sprite height in screen pixels, multiple of 2^IWIDTH
- HRES, 640, screen width; VRES, 480, screen height
- TRANSPARENT, 0, texel value that is not written
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; accepted only in IDLE
- hoffset  input  HWIDTH  screen x of sprite top-left, sampled on accepted start
- voffset  input  VWIDTH  screen y of sprite top-left, sampled on accepted start
- hflip, vflip  input  1 each  mirror controls, sampled on accepted start
- busy  output  1  high from the cycle after accept until done
- done  output  1  one-cycle pulse at completion
- rom_addr  output  AWIDTH  texel ROM address (registered)
- rom_data  input  DWIDTH  texel, valid one cycle after rom_addr is presented
- fb_we  output  1  framebuffer write valid
- fb_ready  input  1  framebuffer accepts write when fb_we && fb_ready
- fb_addr  output  FWIDTH  framebuffer pixel address
- fb_data  output  DWIDTH  pixel to write

## Operation
- States: IDLE, FETCH, WAIT, WRITE, DONE.
- IDLE: start=1 latches offsets/flips, clears x,y to 0, goes to FETCH. start outside IDLE is ignored.
- Iteration: sprite-local x in 0..HSIZE-1 (inner), y in 0..VSIZE-1 (outer), row-major.
- Source: hx = hflip ? HSIZE-1-x : x; vy = vflip ? VSIZE-1-y : y. rom_addr = (vy>>IWIDTH)*(HSIZE>>IWIDTH) + (hx>>IWIDTH), computed at AWIDTH bits.
- Destination: sx = hoffset+x, sy = voffset+y, computed at HWIDTH+1 / VWIDTH+1 bits (no wrap). fb_addr = sy*HRES + sx at FWIDTH bits.
- FETCH: rom_addr holds the current pixel's address; go to WAIT.
- WAIT: rom_data valid. If sx<HRES, sy<VRES and rom_data!=TRANSPARENT, register fb_addr/fb_data, set fb_we, go to WRITE; otherwise advance pixel.
- WRITE: hold fb_we, fb_addr, fb_data stable until fb_ready=1; on handshake clear fb_we and advance pixel.
- Advance: if last pixel (x=HSIZE-1, y=VSIZE-1) go to DONE, else step x (wrap to 0, y+1) and go to FETCH.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Reset (any time, including mid-sprite): state IDLE, busy=0, done=0, fb_we=0, rom_addr=0, fb_addr=0, fb_data=0, counters 0; a write in flight is dropped.

## Timing
- Accept at edge N with start=1 in IDLE; busy=1 and FETCH from N+1.
- Per pixel: 3 cycles when written with fb_ready=1 (FETCH, WAIT, WRITE); 2 cycles when skipped; +1 per cycle of fb_ready=0.
- done asserts the cycle after the last pixel's WRITE handshake or skip; busy low in that same cycle; new start accepted the following cycle.
- fb_we never drops without a handshake except on reset.

## Test plan
- HSIZE=VSIZE=4, IWIDTH=0, offsets (0,0), no flip, ROM data=addr+1, fb_ready=1 -> 16 writes, fb_addr 0..3, 640..643, 1280..1283, 1920..1923, data 1..16; done 49 cycles after accept.
- Same with hflip=1, vflip=1 -> first write fb_addr 0 data 16, last write fb_addr 1923 data 1.
- hoffset=638, voffset=478 -> only 4 writes (addr 306558, 306559, 307198, 307199); done still pulses once.
- Texels 0 at even ROM addresses, TRANSPARENT=0 -> 8 writes, skipped pixels cost 2 cycles.
- fb_ready low 5 cycles during first write -> fb_we held, fb_addr/fb_data stable, completion delayed 5 cycles; start pulses while busy ignored.
- IWIDTH=1, HSIZE=VSIZE=8 -> x=0,1 both read rom_addr 0, row y=2 reads rom_addr 4; rst_n low mid-sprite -> all outputs 0 immediately, next start restarts from pixel (0,0).
